// File: rtl/rvfi_pkg.sv
// Shared RVFI shadow types for the commit tracker and the top-level RVFI hookup.
package rvfi_pkg;

    localparam int unsigned ORDER_W = 64;

    // Everything the tracker remembers about one ROB entry until it retires.
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_entry_t;

    // Number of set bits of v strictly below bit position n (n = 32 gives a full popcount).
    function automatic logic [7:0] count_below(input logic [31:0] v, input int unsigned n);
        logic [7:0] c;
        c = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n && v[i]) c = c + 8'd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/rvfi_tracker_lane.sv
// One RVFI commit lane: entry read mux, order offset, x0 zeroing and the output register.
module rvfi_tracker_lane
    import rvfi_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned LANE      = 0,
    localparam int unsigned IDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  rvfi_entry_t         entries [ROB_DEPTH],
    input  logic [CHANNELS-1:0] commit_valid,
    input  logic [IDX_W-1:0]    commit_idx,
    input  logic [ORDER_W-1:0]  order_q,
    output logic                rvfi_valid,
    output logic [ORDER_W-1:0]  rvfi_order,
    output logic [31:0]         rvfi_insn,
    output logic [4:0]          rvfi_rs1_addr,
    output logic [4:0]          rvfi_rs2_addr,
    output logic [31:0]         rvfi_rs1_rdata,
    output logic [31:0]         rvfi_rs2_rdata,
    output logic [4:0]          rvfi_rd_addr,
    output logic [31:0]         rvfi_rd_wdata,
    output logic [31:0]         rvfi_pc_rdata,
    output logic [31:0]         rvfi_pc_wdata,
    output logic [31:0]         rvfi_mem_addr,
    output logic [3:0]          rvfi_mem_rmask,
    output logic [3:0]          rvfi_mem_wmask,
    output logic [31:0]         rvfi_mem_rdata,
    output logic [31:0]         rvfi_mem_wdata
);

    rvfi_entry_t          pkt_d, pkt_q;
    logic [ORDER_W-1:0]   order_d, order_r;
    logic                 valid_r;

    // Select the committing entry and apply the x0 read/write zeroing rules.
    always_comb begin
        pkt_d = entries[commit_idx];
        if (pkt_d.rd_addr == 5'd0)  pkt_d.rd_wdata  = '0;
        if (pkt_d.rs1_addr == 5'd0) pkt_d.rs1_rdata = '0;
        if (pkt_d.rs2_addr == 5'd0) pkt_d.rs2_rdata = '0;
        order_d = order_q + ORDER_W'(count_below(32'(commit_valid), LANE));
    end

    // Output register, refreshed every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            order_r <= '0;
            pkt_q   <= '0;
        end else begin
            valid_r <= commit_valid[LANE];
            order_r <= order_d;
            pkt_q   <= pkt_d;
        end
    end

    assign rvfi_valid     = valid_r;
    assign rvfi_order     = order_r;
    assign rvfi_insn      = pkt_q.insn;
    assign rvfi_rs1_addr  = pkt_q.rs1_addr;
    assign rvfi_rs2_addr  = pkt_q.rs2_addr;
    assign rvfi_rs1_rdata = pkt_q.rs1_rdata;
    assign rvfi_rs2_rdata = pkt_q.rs2_rdata;
    assign rvfi_rd_addr   = pkt_q.rd_addr;
    assign rvfi_rd_wdata  = pkt_q.rd_wdata;
    assign rvfi_pc_rdata  = pkt_q.pc_rdata;
    assign rvfi_pc_wdata  = pkt_q.pc_wdata;
    assign rvfi_mem_addr  = pkt_q.mem_addr;
    assign rvfi_mem_rmask = pkt_q.mem_rmask;
    assign rvfi_mem_wmask = pkt_q.mem_wmask;
    assign rvfi_mem_rdata = pkt_q.mem_rdata;
    assign rvfi_mem_wdata = pkt_q.mem_wdata;

endmodule

// File: rtl/rvfi_tracker.sv
// RVFI commit-stream producer shadowing per-ROB-entry retirement data.
// Define RVFI_TRACKER_CHECK_EN to track writeback completion and flag commits of
// entries that never wrote back (sticky err); otherwise err is tied to 0.
module rvfi_tracker
    import rvfi_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned CHANNELS  = 1,
    localparam int unsigned IDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        disp_valid,
    input  logic [IDX_W-1:0]            disp_idx,
    input  logic [31:0]                 disp_inst,
    input  logic [31:0]                 disp_pc_rdata,
    input  logic [4:0]                  disp_rs1_addr,
    input  logic [4:0]                  disp_rs2_addr,
    input  logic [4:0]                  disp_rd_addr,
    input  logic                        wb_valid,
    input  logic [IDX_W-1:0]            wb_idx,
    input  logic [31:0]                 wb_rs1_rdata,
    input  logic [31:0]                 wb_rs2_rdata,
    input  logic [31:0]                 wb_rd_wdata,
    input  logic [31:0]                 wb_pc_wdata,
    input  logic                        mem_valid,
    input  logic [IDX_W-1:0]            mem_idx,
    input  logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_rdata,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_rmask,
    input  logic [3:0]                  mem_wmask,
    input  logic [CHANNELS-1:0]         commit_valid,
    input  logic [CHANNELS*IDX_W-1:0]   commit_idx,
    output logic [CHANNELS-1:0]         rvfi_valid,
    output logic [CHANNELS*ORDER_W-1:0] rvfi_order,
    output logic [CHANNELS*32-1:0]      rvfi_insn,
    output logic [CHANNELS*5-1:0]       rvfi_rs1_addr,
    output logic [CHANNELS*5-1:0]       rvfi_rs2_addr,
    output logic [CHANNELS*32-1:0]      rvfi_rs1_rdata,
    output logic [CHANNELS*32-1:0]      rvfi_rs2_rdata,
    output logic [CHANNELS*5-1:0]       rvfi_rd_addr,
    output logic [CHANNELS*32-1:0]      rvfi_rd_wdata,
    output logic [CHANNELS*32-1:0]      rvfi_pc_rdata,
    output logic [CHANNELS*32-1:0]      rvfi_pc_wdata,
    output logic [CHANNELS*32-1:0]      rvfi_mem_addr,
    output logic [CHANNELS*4-1:0]       rvfi_mem_rmask,
    output logic [CHANNELS*4-1:0]       rvfi_mem_wmask,
    output logic [CHANNELS*32-1:0]      rvfi_mem_rdata,
    output logic [CHANNELS*32-1:0]      rvfi_mem_wdata,
    output logic                        err
);

    rvfi_entry_t        entries [ROB_DEPTH];
    logic [ORDER_W-1:0] order_q;

    // Shadow storage (not reset); mem writes land after dispatch so a same-cycle LSU write wins.
    always_ff @(posedge clk) begin
        if (disp_valid) begin
            entries[disp_idx].insn      <= disp_inst;
            entries[disp_idx].pc_rdata  <= disp_pc_rdata;
            entries[disp_idx].rs1_addr  <= disp_rs1_addr;
            entries[disp_idx].rs2_addr  <= disp_rs2_addr;
            entries[disp_idx].rd_addr   <= disp_rd_addr;
            entries[disp_idx].mem_rmask <= '0;
            entries[disp_idx].mem_wmask <= '0;
        end
        if (wb_valid) begin
            entries[wb_idx].rs1_rdata <= wb_rs1_rdata;
            entries[wb_idx].rs2_rdata <= wb_rs2_rdata;
            entries[wb_idx].rd_wdata  <= wb_rd_wdata;
            entries[wb_idx].pc_wdata  <= wb_pc_wdata;
        end
        if (mem_valid) begin
            entries[mem_idx].mem_addr  <= mem_addr;
            entries[mem_idx].mem_rdata <= mem_rdata;
            entries[mem_idx].mem_wdata <= mem_wdata;
            entries[mem_idx].mem_rmask <= mem_rmask;
            entries[mem_idx].mem_wmask <= mem_wmask;
        end
    end

    // Retirement order counter; advances by the number of lanes committing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) order_q <= '0;
        else        order_q <= order_q + ORDER_W'(count_below(32'(commit_valid), CHANNELS));
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        rvfi_tracker_lane #(
            .ROB_DEPTH (ROB_DEPTH),
            .CHANNELS  (CHANNELS),
            .LANE      (k)
        ) u_lane (
            .clk            (clk),
            .rst_n          (rst_n),
            .entries        (entries),
            .commit_valid   (commit_valid),
            .commit_idx     (commit_idx[k*IDX_W +: IDX_W]),
            .order_q        (order_q),
            .rvfi_valid     (rvfi_valid[k]),
            .rvfi_order     (rvfi_order[k*ORDER_W +: ORDER_W]),
            .rvfi_insn      (rvfi_insn[k*32 +: 32]),
            .rvfi_rs1_addr  (rvfi_rs1_addr[k*5 +: 5]),
            .rvfi_rs2_addr  (rvfi_rs2_addr[k*5 +: 5]),
            .rvfi_rs1_rdata (rvfi_rs1_rdata[k*32 +: 32]),
            .rvfi_rs2_rdata (rvfi_rs2_rdata[k*32 +: 32]),
            .rvfi_rd_addr   (rvfi_rd_addr[k*5 +: 5]),
            .rvfi_rd_wdata  (rvfi_rd_wdata[k*32 +: 32]),
            .rvfi_pc_rdata  (rvfi_pc_rdata[k*32 +: 32]),
            .rvfi_pc_wdata  (rvfi_pc_wdata[k*32 +: 32]),
            .rvfi_mem_addr  (rvfi_mem_addr[k*32 +: 32]),
            .rvfi_mem_rmask (rvfi_mem_rmask[k*4 +: 4]),
            .rvfi_mem_wmask (rvfi_mem_wmask[k*4 +: 4]),
            .rvfi_mem_rdata (rvfi_mem_rdata[k*32 +: 32]),
            .rvfi_mem_wdata (rvfi_mem_wdata[k*32 +: 32])
        );
    end

`ifdef RVFI_TRACKER_CHECK_EN
    logic [ROB_DEPTH-1:0] wb_done_q, wb_done_d;
    logic                 err_q, err_hit;

    // Writeback-done flags: dispatch clears, writeback sets, flush clears everything.
    always_comb begin
        wb_done_d = wb_done_q;
        if (disp_valid) wb_done_d[disp_idx] = 1'b0;
        if (wb_valid)   wb_done_d[wb_idx]   = 1'b1;
        if (flush)      wb_done_d           = '0;
        err_hit = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (commit_valid[k] && !wb_done_q[commit_idx[k*IDX_W +: IDX_W]]) err_hit = 1'b1;
        end
    end

    // Flag register and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_done_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wb_done_q <= wb_done_d;
            err_q     <= err_q | err_hit;
        end
    end

    assign err = err_q;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_tracker.sv
// Randomized self-checking bench for rvfi_tracker (2 lanes, 16 entries) against a
// per-entry field model; err expectation follows RVFI_TRACKER_CHECK_EN.
module tb_rvfi_tracker;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CH    = 2;
    localparam int unsigned IW    = 4;
`ifdef RVFI_TRACKER_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic disp_valid = 1'b0, wb_valid = 1'b0, mem_valid = 1'b0;
    logic [IW-1:0] disp_idx = '0, wb_idx = '0, mem_idx = '0;
    logic [31:0] disp_inst = '0, disp_pc_rdata = '0;
    logic [4:0] disp_rs1_addr = '0, disp_rs2_addr = '0, disp_rd_addr = '0;
    logic [31:0] wb_rs1_rdata = '0, wb_rs2_rdata = '0, wb_rd_wdata = '0, wb_pc_wdata = '0;
    logic [31:0] mem_addr = '0, mem_rdata = '0, mem_wdata = '0;
    logic [3:0] mem_rmask = '0, mem_wmask = '0;
    logic [CH-1:0] commit_valid = '0;
    logic [CH*IW-1:0] commit_idx = '0;

    logic [CH-1:0]    rvfi_valid;
    logic [CH*64-1:0] rvfi_order;
    logic [CH*32-1:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [CH*32-1:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [CH*5-1:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [CH*4-1:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic             err;

    always #5 clk = ~clk;

    rvfi_tracker #(
        .ROB_DEPTH (DEPTH),
        .CHANNELS  (CH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_idx       (disp_idx),
        .disp_inst      (disp_inst),
        .disp_pc_rdata  (disp_pc_rdata),
        .disp_rs1_addr  (disp_rs1_addr),
        .disp_rs2_addr  (disp_rs2_addr),
        .disp_rd_addr   (disp_rd_addr),
        .wb_valid       (wb_valid),
        .wb_idx         (wb_idx),
        .wb_rs1_rdata   (wb_rs1_rdata),
        .wb_rs2_rdata   (wb_rs2_rdata),
        .wb_rd_wdata    (wb_rd_wdata),
        .wb_pc_wdata    (wb_pc_wdata),
        .mem_valid      (mem_valid),
        .mem_idx        (mem_idx),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_wdata      (mem_wdata),
        .mem_rmask      (mem_rmask),
        .mem_wmask      (mem_wmask),
        .commit_valid   (commit_valid),
        .commit_idx     (commit_idx),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_rs1_addr  (rvfi_rs1_addr),
        .rvfi_rs2_addr  (rvfi_rs2_addr),
        .rvfi_rs1_rdata (rvfi_rs1_rdata),
        .rvfi_rs2_rdata (rvfi_rs2_rdata),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_pc_wdata  (rvfi_pc_wdata),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_rmask (rvfi_mem_rmask),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .rvfi_mem_rdata (rvfi_mem_rdata),
        .rvfi_mem_wdata (rvfi_mem_wdata),
        .err            (err)
    );

    // Reference model: what each ROB entry should report when it retires.
    logic [31:0] m_insn [DEPTH], m_pc_r [DEPTH], m_rs1d [DEPTH], m_rs2d [DEPTH];
    logic [31:0] m_rdw [DEPTH], m_pc_w [DEPTH], m_maddr [DEPTH], m_mrd [DEPTH], m_mwd [DEPTH];
    logic [4:0]  m_rs1a [DEPTH], m_rs2a [DEPTH], m_rda [DEPTH];
    logic [3:0]  m_rmask [DEPTH], m_wmask [DEPTH];
    bit          m_done [DEPTH];
    longint unsigned m_order = 0;
    bit          m_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; wb_valid = 1'b0; mem_valid = 1'b0;
        commit_valid = '0;
    endtask

    task automatic set_disp(input int idx, input logic [31:0] inst, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd);
        disp_valid = 1'b1; disp_idx = IW'(idx); disp_inst = inst; disp_pc_rdata = $urandom;
        disp_rs1_addr = rs1; disp_rs2_addr = rs2; disp_rd_addr = rd;
    endtask

    task automatic set_wb(input int idx, input logic [31:0] rdw);
        wb_valid = 1'b1; wb_idx = IW'(idx); wb_rd_wdata = rdw;
        wb_rs1_rdata = $urandom; wb_rs2_rdata = $urandom; wb_pc_wdata = $urandom;
    endtask

    task automatic set_mem(input int idx, input logic [31:0] addr, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] rd);
        mem_valid = 1'b1; mem_idx = IW'(idx); mem_addr = addr; mem_rmask = rm; mem_wmask = wm;
        mem_rdata = rd; mem_wdata = $urandom;
    endtask

    task automatic set_commit(input int lanes, input int i0, input int i1);
        commit_valid = (lanes == 0) ? 2'b00 : (lanes == 1) ? 2'b01 : 2'b11;
        commit_idx = {IW'(i1), IW'(i0)};
    endtask

    // One clock with the inputs currently driven; checks outputs, then advances the model.
    task automatic step();
        logic [CH-1:0] cv;
        int            ci [CH];
        int            pre;
        int            e;
        cv = commit_valid;
        for (int k = 0; k < CH; k++) ci[k] = int'(commit_idx[k*IW +: IW]);
        @(posedge clk);
        #1;
        pre = 0;
        for (int k = 0; k < CH; k++) begin
            check($sformatf("valid%0d", k), 64'(rvfi_valid[k]), 64'(cv[k]));
            if (cv[k]) begin
                e = ci[k];
                check($sformatf("order%0d", k), rvfi_order[k*64 +: 64], m_order + 64'(pre));
                check($sformatf("insn%0d", k), 64'(rvfi_insn[k*32 +: 32]), 64'(m_insn[e]));
                check($sformatf("pc_r%0d", k), 64'(rvfi_pc_rdata[k*32 +: 32]), 64'(m_pc_r[e]));
                check($sformatf("pc_w%0d", k), 64'(rvfi_pc_wdata[k*32 +: 32]), 64'(m_pc_w[e]));
                check($sformatf("rd%0d", k), 64'(rvfi_rd_addr[k*5 +: 5]), 64'(m_rda[e]));
                check($sformatf("rdw%0d", k), 64'(rvfi_rd_wdata[k*32 +: 32]),
                      (m_rda[e] == 0) ? 64'd0 : 64'(m_rdw[e]));
                check($sformatf("rs1d%0d", k), 64'(rvfi_rs1_rdata[k*32 +: 32]),
                      (m_rs1a[e] == 0) ? 64'd0 : 64'(m_rs1d[e]));
                check($sformatf("rs2d%0d", k), 64'(rvfi_rs2_rdata[k*32 +: 32]),
                      (m_rs2a[e] == 0) ? 64'd0 : 64'(m_rs2d[e]));
                check($sformatf("regs%0d", k),
                      64'({rvfi_rs1_addr[k*5 +: 5], rvfi_rs2_addr[k*5 +: 5]}),
                      64'({m_rs1a[e], m_rs2a[e]}));
                check($sformatf("masks%0d", k),
                      64'({rvfi_mem_rmask[k*4 +: 4], rvfi_mem_wmask[k*4 +: 4]}),
                      64'({m_rmask[e], m_wmask[e]}));
                check($sformatf("maddr%0d", k), 64'(rvfi_mem_addr[k*32 +: 32]), 64'(m_maddr[e]));
                check($sformatf("mdata%0d", k),
                      {rvfi_mem_rdata[k*32 +: 32], rvfi_mem_wdata[k*32 +: 32]},
                      {m_mrd[e], m_mwd[e]});
                if (ERR_EN && !m_done[e]) m_err = 1'b1;
                pre++;
            end
        end
        check("err", 64'(err), 64'(m_err));
        m_order += longint'(pre);
        if (disp_valid) begin
            m_insn[disp_idx] = disp_inst; m_pc_r[disp_idx] = disp_pc_rdata;
            m_rs1a[disp_idx] = disp_rs1_addr; m_rs2a[disp_idx] = disp_rs2_addr;
            m_rda[disp_idx] = disp_rd_addr; m_rmask[disp_idx] = '0; m_wmask[disp_idx] = '0;
            m_done[disp_idx] = 1'b0;
        end
        if (wb_valid) begin
            m_rs1d[wb_idx] = wb_rs1_rdata; m_rs2d[wb_idx] = wb_rs2_rdata;
            m_rdw[wb_idx] = wb_rd_wdata; m_pc_w[wb_idx] = wb_pc_wdata; m_done[wb_idx] = 1'b1;
        end
        if (mem_valid) begin
            m_maddr[mem_idx] = mem_addr; m_mrd[mem_idx] = mem_rdata; m_mwd[mem_idx] = mem_wdata;
            m_rmask[mem_idx] = mem_rmask; m_wmask[mem_idx] = mem_wmask;
        end
        if (flush) for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
    endtask

    initial begin
        int a, b, lanes;
        for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;

        // Reset values
        #12;
        check("rst_valid", 64'(rvfi_valid), 64'd0);
        check("rst_order", rvfi_order[63:0], 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every entry so all shadow fields hold known values
        for (int i = 0; i < DEPTH; i++) begin
            idle(); set_disp(i, $urandom, 5'($urandom), 5'($urandom), 5'($urandom)); step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(); set_wb(i, $urandom); set_mem(i, $urandom, 4'($urandom), 4'($urandom), $urandom);
            step();
        end

        // addi x1, x0, 10 at idx 3
        idle(); set_disp(3, 32'h00A00093, 5'd0, 5'd0, 5'd1); step();
        idle(); set_wb(3, 32'hA); step();
        idle(); set_commit(1, 3, 0); step();
        check("t1_valid", 64'(rvfi_valid[0]), 64'd1);
        check("t1_order", rvfi_order[63:0], 64'd0);
        check("t1_rdw", 64'(rvfi_rd_wdata[31:0]), 64'hA);
        check("t1_masks", 64'({rvfi_mem_rmask[3:0], rvfi_mem_wmask[3:0]}), 64'd0);
        idle(); step();

        // Six more singles, then a dual commit at orders 7 and 8
        for (int j = 0; j < 6; j++) begin
            idle(); set_commit(1, 8 + j, 0); step();
        end
        idle(); set_commit(2, 4, 5); step();
        check("t2_order0", rvfi_order[63:0], 64'd7);
        check("t2_order1", rvfi_order[127:64], 64'd8);
        idle(); set_commit(1, 7, 0); step();
        check("t2_next", rvfi_order[63:0], 64'd9);

        // Load at idx 2 with same-cycle wb and mem, then re-dispatch as an ALU op
        idle(); set_disp(2, 32'h0040A103, 5'd1, 5'd0, 5'd2); step();
        idle(); set_wb(2, 32'hBEEF); set_mem(2, 32'h1004, 4'b0011, 4'b0000, 32'hBEEF); step();
        idle(); set_commit(1, 2, 0); step();
        check("t3_maddr", 64'(rvfi_mem_addr[31:0]), 64'h1004);
        check("t3_rmask", 64'(rvfi_mem_rmask[3:0]), 64'h3);
        check("t3_rdata", 64'(rvfi_mem_rdata[31:0]), 64'hBEEF);
        idle(); set_disp(2, 32'h00208133, 5'd1, 5'd2, 5'd2); step();
        idle(); set_wb(2, 32'h55); step();
        idle(); set_commit(1, 2, 0); step();
        check("t3_alu_masks", 64'({rvfi_mem_rmask[3:0], rvfi_mem_wmask[3:0]}), 64'd0);

        // Read-before-write at idx 6
        idle(); set_disp(6, 32'h11111111, 5'd3, 5'd4, 5'd5); step();
        idle(); set_wb(6, 32'h66); step();
        idle(); set_commit(1, 6, 0); set_disp(6, 32'h22222222, 5'd3, 5'd4, 5'd5); step();
        check("t4_old", 64'(rvfi_insn[31:0]), 64'h11111111);
        idle(); set_wb(6, 32'h77); step();
        idle(); set_commit(1, 6, 0); step();
        check("t4_new", 64'(rvfi_insn[31:0]), 64'h22222222);

        // Commit after flush without writeback
        idle(); step();
        check("t5_err_before", 64'(err), 64'd0);
        idle(); set_disp(1, 32'h00000013, 5'd0, 5'd0, 5'd0); step();
        idle(); flush = 1'b1; step();
        idle(); set_commit(1, 1, 0); step();
        idle(); step();
        check("t5_err", 64'(err), 64'(ERR_EN));
        step();
        check("t5_err_sticky", 64'(err), 64'(ERR_EN));

        // Asynchronous reset after order 20
        while (m_order < 21) begin
            idle(); set_commit(1, 9, 0); step();
        end
        check("t6_last", rvfi_order[63:0], 64'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(rvfi_valid), 64'd0);
        check("t6_async_order", rvfi_order[63:0], 64'd0);
        check("t6_async_err", 64'(err), 64'd0);
        m_order = 0; m_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_first", rvfi_order[63:0], 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(1, 0) == 1)
                set_disp($urandom_range(DEPTH - 1, 0), $urandom, 5'($urandom), 5'($urandom),
                         5'($urandom % 4));
            if ($urandom_range(1, 0) == 1) begin
                a = $urandom_range(DEPTH - 1, 0);
                if (!(disp_valid && IW'(a) == disp_idx)) set_wb(a, $urandom);
            end
            if ($urandom_range(2, 0) == 0)
                set_mem($urandom_range(DEPTH - 1, 0), $urandom, 4'($urandom), 4'($urandom),
                        $urandom);
            if (!wb_valid && $urandom_range(19, 0) == 0) flush = 1'b1;
            lanes = $urandom_range(2, 0);
            a = $urandom_range(DEPTH - 1, 0);
            b = $urandom_range(DEPTH - 1, 0);
            set_commit(lanes, a, b);
            step();
        end
        idle(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
